// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_controller_pkg;

  // Memory port owner: idle, data access in flight, instruction fetch in flight
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBusyD = 2'b01,
    StBusyI = 2'b10
  } hc_state_e;

  // Address/data mux select for the unified memory port
  localparam logic MemSelInstr = 1'b0;
  localparam logic MemSelData  = 1'b1;

endpackage

// File: rtl/pipeline_hazard_controller_load_use_detect.sv
// Load-use hazard detection: a load in ID/EX whose rd feeds the instruction in ID.
module pipeline_hazard_controller_load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  output logic       load_use
);

  // x0 never carries a dependency, so rd==0 cannot cause a stall
  always_comb begin
    load_use = id_ex_mem_read && (id_ex_rd != 5'd0) &&
               ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Sequencing controller for a 5-stage pipeline sharing one single-ported memory
// between instruction fetch and load/store. Data accesses take priority; the
// pipeline advances only when the fetch access completes.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] id_ex_rd,
  input  logic       id_ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       if_fetch_req,
  input  logic       mem_data_req,
  input  logic       mem_ready,
  output logic       mem_start,
  output logic       mem_sel,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       id_ex_bubble,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       freeze,
  output logic       timeout_err
);

  hc_state_e        state_q, state_d;
  logic             data_done_q, data_done_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic             timeout_err_q, timeout_err_d;
  logic             start, sel, adv, load_use, wdog_expired;

  pipeline_hazard_controller_load_use_detect u_load_use_detect (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .load_use       (load_use)
  );

  // Completion in the same cycle beats the watchdog
  assign wdog_expired = (wdog_q == CNT_W'(TIMEOUT)) && !mem_ready;

  // Next-state, data_done, watchdog and memory-port decode
  always_comb begin
    state_d       = state_q;
    data_done_d   = data_done_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    start         = 1'b0;
    sel           = MemSelInstr;
    adv           = 1'b0;
    unique case (state_q)
      StIdle: begin
        wdog_d = '0;
        // A data access already served for this instruction is not repeated
        if (mem_data_req && !data_done_q) begin
          start   = 1'b1;
          sel     = MemSelData;
          state_d = StBusyD;
        end else if (if_fetch_req) begin
          start   = 1'b1;
          state_d = StBusyI;
        end
      end
      StBusyD: begin
        sel = MemSelData;
        if (mem_ready) begin
          data_done_d = 1'b1;
          wdog_d      = '0;
          // Chain straight into the fetch to save the IDLE cycle
          if (if_fetch_req) begin
            start   = 1'b1;
            sel     = MemSelInstr;
            state_d = StBusyI;
          end else begin
            state_d = StIdle;
          end
        end else if (wdog_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
          wdog_d        = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StBusyI: begin
        if (mem_ready) begin
          adv         = 1'b1;
          data_done_d = 1'b0;
          wdog_d      = '0;
          state_d     = StIdle;
        end else if (wdog_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StIdle;
          wdog_d        = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, data_done, watchdog and sticky error registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      data_done_q   <= 1'b0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_done_q   <= data_done_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Pipeline control decode; rst gates the IDLE launch so nothing starts in reset
  always_comb begin
    mem_start    = start && !rst;
    mem_sel      = sel && !rst;
    freeze       = !adv;
    pc_write     = adv && (ex_branch_taken || !load_use);
    if_id_write  = adv && (ex_branch_taken || !load_use);
    id_ex_bubble = adv && !ex_branch_taken && load_use;
    if_id_flush  = adv && ex_branch_taken;
    id_ex_flush  = adv && ex_branch_taken;
    timeout_err  = timeout_err_q;
  end

endmodule
